// File: rtl/enc_pkg.sv
// Shared constants and helpers for the sequential 8-to-3 priority encoder.
package enc_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N);
  localparam bit HI_FIRST_DEF = 1'b1;

  // One-hot mask with only bit idx set; used to retire the granted line.
  function automatic logic [N-1:0] onehot(input logic [CW-1:0] idx);
    logic [N-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/enc8x3_seq_if.sv
// Grant handshake between the encoder (master) and its consumer (slave).
interface enc8x3_seq_if;

  logic                     valid;
  logic                     ready;
  logic [enc_pkg::CW-1:0]   code;
  logic                     multi;

  modport master (output valid, output code, output multi, input ready);
  modport slave  (input valid, input code, input multi, output ready);

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder with selectable winning end.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit HI_FIRST = HI_FIRST_DEF
) (
  input  logic [N-1:0]  src,
  output logic [CW-1:0] idx,
  output logic          any,
  output logic          multi
);

  // Scan towards the winning end so the last hit seen has priority.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = HI_FIRST ? i : (N - 1 - i);
      if (src[j]) idx = j[CW-1:0];
    end
    any   = |src;
    multi = ($countones(src) > 1);
  end

endmodule

// File: rtl/enc8x3_seq.sv
// Sticky request collector that grants one encoded line per handshake.
module enc8x3_seq
  import enc_pkg::*;
#(
  parameter bit HI_FIRST = HI_FIRST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N-1:0]        d,
  input  logic                flush,
  enc8x3_seq_if.master        bus,
  output logic                busy
);

  logic [N-1:0]  pend;
  logic [N-1:0]  cap;
  logic [N-1:0]  src;
  logic [CW-1:0] sel_idx;
  logic          sel_any;
  logic          sel_multi;
  logic          load;
  logic          valid_q;
  logic [CW-1:0] code_q;
  logic          multi_q;

  // Merge this cycle's strobes with outstanding requests before picking.
  always_comb begin
    cap  = en ? d : '0;
    src  = pend | cap;
    load = (!valid_q || bus.ready) && sel_any;
  end

  prio_enc8 #(.HI_FIRST(HI_FIRST)) u_prio (
    .src   (src),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  // Pending register and output register; flush beats load and take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
    end else if (flush) begin
      pend    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      code_q  <= sel_idx;
      multi_q <= sel_multi;
      valid_q <= 1'b1;
      pend    <= src & ~onehot(sel_idx);
    end else begin
      pend <= src;
      if (valid_q && bus.ready) valid_q <= 1'b0;
    end
  end

  assign bus.valid = valid_q;
  assign bus.code  = code_q;
  assign bus.multi = multi_q;
  assign busy      = |pend;

endmodule
